fmap_pingpong_buffer: RTL

- Double-buffered (ping-pong) feature-map stream buffer between two VGG16 conv layers.
- Captures one full WIDTH x HEIGHT map of CH-channel packed pixels from the upstream layer's valid stream.
- Replays that map to the downstream layer with valid/ready backpressure while the second bank captures the next map.
- Replaces ad hoc capture RAMs and gives layers a synthesizable, frame-aware handoff.

---
 rtl/fmap_pingpong_buffer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/fmap_pingpong_buffer.sv
// ---------------------------------------------------------------------------
// fmap_pingpong_buffer
//   Two-bank feature-map buffer. One bank captures a full WIDTH x HEIGHT map
//   from the upstream stream while the other replays its map downstream with
//   valid/ready flow control.
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fmap_pingpong_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int CH         = 16,
  parameter int WIDTH      = 56,
  parameter int HEIGHT     = 56
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_WIDTH*CH-1:0]   i_data,
  input  logic                       valid_in,
  output logic                       in_ready,
  output logic [DATA_WIDTH*CH-1:0]   o_data,
  output logic                       valid_out,
  input  logic                       ready_in,
  output logic                       frame_done,
  output logic                       overflow,
  output logic                       wr_bank,
  output logic                       rd_bank
);

  localparam int DEPTH = WIDTH * HEIGHT;
  localparam int BW    = DATA_WIDTH * CH;
  localparam int CW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int AW    = $clog2(2 * DEPTH);
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_t;

  typedef enum logic [1:0] {
    RD_IDLE     = 2'd0,
    RD_PREFETCH = 2'd1,
    RD_STREAM   = 2'd2
  } rd_state_t;

  // Bank b occupies addresses b*DEPTH .. b*DEPTH+DEPTH-1
  logic [BW-1:0] mem [2*DEPTH];

  bank_t         bank_state [2];
  bank_t         bank_nxt   [2];
  rd_state_t     rd_state;
  logic [CW-1:0] wr_cnt;
  logic [CW-1:0] rd_cnt;
  logic [CW-1:0] rd_idx;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic          wr_fire;
  logic          wr_last;
  logic          rd_fire;
  logic          rd_last;
  logic          rd_start;
  logic          rd_chain;
  logic          wr_bank_nxt;
  logic          in_ready_nxt;

  // Next bank states from write and read events; write side is applied first
  // so a bank completing this cycle can be chained straight into a drain.
  always_comb begin
    wr_fire  = valid_in && in_ready;
    wr_last  = wr_fire && (wr_cnt == LAST);
    rd_fire  = valid_out && ready_in;
    rd_last  = rd_fire && (rd_cnt == LAST);
    rd_start = (rd_state == RD_IDLE) && (bank_state[rd_bank] == BANK_FULL);
    rd_chain = 1'b0;

    bank_nxt[0] = bank_state[0];
    bank_nxt[1] = bank_state[1];

    if (wr_fire) begin
      bank_nxt[wr_bank] = wr_last ? BANK_FULL : BANK_FILLING;
    end
    if (rd_start) begin
      bank_nxt[rd_bank] = BANK_DRAINING;
    end
    if (rd_last) begin
      bank_nxt[rd_bank] = BANK_EMPTY;
      if (bank_nxt[~rd_bank] == BANK_FULL) begin
        rd_chain           = 1'b1;
        bank_nxt[~rd_bank] = BANK_DRAINING;
      end
    end

    wr_bank_nxt  = wr_bank ^ wr_last;
    in_ready_nxt = (bank_nxt[wr_bank_nxt] == BANK_EMPTY) ||
                   (bank_nxt[wr_bank_nxt] == BANK_FILLING);

    // PREFETCH loads beat 0; STREAM loads the beat after the one on o_data
    rd_idx  = (rd_state == RD_STREAM) ? (rd_cnt + CW'(1)) : '0;
    wr_addr = wr_bank ? (AW'(DEPTH) + AW'(wr_cnt)) : AW'(wr_cnt);
    rd_addr = rd_bank ? (AW'(DEPTH) + AW'(rd_idx)) : AW'(rd_idx);
  end

  // Bank occupancy state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_state[0] <= BANK_EMPTY;
      bank_state[1] <= BANK_EMPTY;
    end else begin
      bank_state[0] <= bank_nxt[0];
      bank_state[1] <= bank_nxt[1];
    end
  end

  // Write side: address counter, bank select, registered ready, sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt   <= '0;
      wr_bank  <= 1'b0;
      in_ready <= 1'b1;
      overflow <= 1'b0;
    end else begin
      wr_bank  <= wr_bank_nxt;
      in_ready <= in_ready_nxt;
      if (wr_fire) begin
        wr_cnt <= wr_last ? '0 : (wr_cnt + CW'(1));
      end
      if (valid_in && !in_ready) begin
        overflow <= 1'b1;
      end
    end
  end

  // Storage array; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_addr] <= i_data;
    end
  end

  // Read FSM: o_data is the synchronous RAM output register, reloaded on every
  // accepted beat so a continuously ready consumer sees no bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state   <= RD_IDLE;
      rd_bank    <= 1'b0;
      rd_cnt     <= '0;
      o_data     <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (rd_state)
        RD_IDLE: begin
          if (rd_start) begin
            rd_state <= RD_PREFETCH;
            rd_cnt   <= '0;
          end
        end
        RD_PREFETCH: begin
          o_data    <= mem[rd_addr];
          valid_out <= 1'b1;
          rd_cnt    <= '0;
          rd_state  <= RD_STREAM;
        end
        RD_STREAM: begin
          if (rd_fire) begin
            if (rd_last) begin
              valid_out  <= 1'b0;
              frame_done <= 1'b1;
              rd_bank    <= ~rd_bank;
              rd_cnt     <= '0;
              rd_state   <= rd_chain ? RD_PREFETCH : RD_IDLE;
            end else begin
              rd_cnt <= rd_cnt + CW'(1);
              o_data <= mem[rd_addr];
            end
          end
        end
        default: begin
          rd_state <= RD_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
